// File: rtl/gb_cpu_mcycle_sequencer.sv
// rtl/gb_cpu_mcycle_sequencer.sv - M-cycle / T-cycle pacing sequencer for the GB CPU core
//
// Paces each decoded instruction through its M-cycles and the T-cycles within each one.
// It also handles conditional early termination, memory stalls, CB-prefix chaining and
// interrupt-dispatch sequencing.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start              begin a new instruction (honoured only while ready=1)
//   mcycle_count       total M-cycles of the decoded instruction (0 -> 1, clamped to MAX_MCYCLES)
//   cb_prefix          current opcode is the 0xCB prefix
//   cond_en            instruction is conditional
//   cond_mcycle        M-cycle whose last T-cycle evaluates the condition
//   cond_taken         condition result
//   stall              memory wait; freezes T-cycle advance
//   irq_req            pending enabled interrupt
//   ready              idle, or in the final T-cycle of the current instruction/dispatch
//   busy               instruction or dispatch in progress
//   m_cycle, t_cycle   current M-cycle / T-cycle indices (0-based)
//   m_start, m_end     first / last T-cycle of each M-cycle (m_end suppressed while stalled)
//   instr_done         last T-cycle of the final M-cycle
//   cb_active          current instruction is the CB-table opcode
//   isr_active         interrupt dispatch in progress
module gb_cpu_mcycle_sequencer #(
   parameter int T_PER_M     = 4,
   parameter int MAX_MCYCLES = 6,
   parameter int ISR_MCYCLES = 5,
   parameter int MC_W        = $clog2(MAX_MCYCLES + 1),
   parameter int T_W         = $clog2(T_PER_M)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [MC_W-1:0] mcycle_count,
   input  logic            cb_prefix,
   input  logic            cond_en,
   input  logic [MC_W-1:0] cond_mcycle,
   input  logic            cond_taken,
   input  logic            stall,
   input  logic            irq_req,
   output logic            ready,
   output logic            busy,
   output logic [MC_W-1:0] m_cycle,
   output logic [T_W-1:0]  t_cycle,
   output logic            m_start,
   output logic            m_end,
   output logic            instr_done,
   output logic            cb_active,
   output logic            isr_active
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ISR  = 2'd2
   } state_t;

   localparam logic [T_W-1:0]  T_LAST   = T_W'(T_PER_M - 1);
   localparam logic [MC_W-1:0] ISR_LAST = MC_W'(ISR_MCYCLES - 1);
   localparam logic [MC_W-1:0] MAX_MC   = MC_W'(MAX_MCYCLES);

   state_t          state_q, state_d;
   logic [MC_W-1:0] m_q, m_d;
   logic [T_W-1:0]  t_q, t_d;
   logic [MC_W-1:0] last_q, last_d;       // index of the final M-cycle
   logic            cond_en_q, cond_en_d;
   logic [MC_W-1:0] cond_mc_q, cond_mc_d;
   logic            cb_prefix_q, cb_prefix_d;   // running instruction is the prefix byte
   logic            cb_pending_q, cb_pending_d; // prefix finished, CB opcode not yet started
   logic            cb_active_q, cb_active_d;
   logic            t0_seen_q;                  // m_start already emitted for this stalled T0

   logic            active;
   logic            at_t_last;
   logic            cond_cut;
   logic            last_m;
   logic            chain;
   logic [MC_W-1:0] count_last;

   assign active    = (state_q != S_IDLE);
   assign at_t_last = (t_q == T_LAST);
   // A not-taken condition turns the condition M-cycle into the final one.
   assign cond_cut  = (state_q == S_RUN) && cond_en_q && (m_q == cond_mc_q) && !cond_taken;
   assign last_m    = (state_q == S_ISR) ? (m_q == ISR_LAST) : ((m_q == last_q) || cond_cut);
   assign chain     = (state_q == S_RUN) && cb_prefix_q;

   assign m_end      = active && at_t_last && !stall;
   assign instr_done = m_end && last_m;
   assign m_start    = active && (t_q == '0) && !t0_seen_q;
   assign ready      = !active || instr_done;
   assign busy       = active;
   assign m_cycle    = m_q;
   assign t_cycle    = t_q;
   assign cb_active  = cb_active_q;
   assign isr_active = (state_q == S_ISR);

   always_comb begin
      count_last = mcycle_count - MC_W'(1);
      if (mcycle_count == '0) begin
         count_last = '0;
      end else if (mcycle_count > MAX_MC) begin
         count_last = MAX_MC - MC_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      m_d          = m_q;
      t_d          = t_q;
      last_d       = last_q;
      cond_en_d    = cond_en_q;
      cond_mc_d    = cond_mc_q;
      cb_prefix_d  = cb_prefix_q;
      cb_pending_d = cb_pending_q;
      cb_active_d  = cb_active_q;

      if ((state_q == S_IDLE && start) ||
          (active && !stall && at_t_last && last_m && start &&
           !(state_q == S_RUN && irq_req && !chain))) begin
         // Accept a new instruction; a completed prefix forces it to be the CB opcode.
         state_d      = S_RUN;
         m_d          = '0;
         t_d          = '0;
         last_d       = count_last;
         cond_en_d    = cond_en;
         cond_mc_d    = cond_mcycle;
         cb_active_d  = cb_pending_q || chain;
         cb_prefix_d  = cb_prefix && !(cb_pending_q || chain);
         cb_pending_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // The CB opcode must follow its prefix without an interrupt in between.
               if (irq_req && !cb_pending_q) begin
                  state_d     = S_ISR;
                  m_d         = '0;
                  t_d         = '0;
                  cb_prefix_d = 1'b0;
               end
            end
            S_RUN, S_ISR: begin
               if (!stall) begin
                  if (!at_t_last) begin
                     t_d = t_q + T_W'(1);
                  end else if (!last_m) begin
                     t_d = '0;
                     m_d = m_q + MC_W'(1);
                  end else begin
                     m_d         = '0;
                     t_d         = '0;
                     cb_active_d = 1'b0;
                     cb_prefix_d = 1'b0;
                     if (state_q == S_RUN && irq_req && !chain) begin
                        state_d = S_ISR;
                     end else begin
                        state_d      = S_IDLE;
                        cb_pending_d = chain;
                     end
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               m_d     = '0;
               t_d     = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         m_q          <= '0;
         t_q          <= '0;
         last_q       <= '0;
         cond_en_q    <= 1'b0;
         cond_mc_q    <= '0;
         cb_prefix_q  <= 1'b0;
         cb_pending_q <= 1'b0;
         cb_active_q  <= 1'b0;
         t0_seen_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_q          <= m_d;
         t_q          <= t_d;
         last_q       <= last_d;
         cond_en_q    <= cond_en_d;
         cond_mc_q    <= cond_mc_d;
         cb_prefix_q  <= cb_prefix_d;
         cb_pending_q <= cb_pending_d;
         cb_active_q  <= cb_active_d;
         // A stall on T0 holds the counters; remember m_start was already issued.
         t0_seen_q    <= active && (t_q == '0) && stall;
      end
   end

endmodule
